// File: rtl/keypad_scan_ctrl.sv
// Column strobe driver and press/release debouncer for the 4x4 keypad.
// Emits one key_valid pulse per debounced press; rescans after debounced release.
module keypad_scan_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COL_DWELL       = 1
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] key_value,
  input  logic [2:0] is_sign_key,
  output logic [3:0] col_shift_reg,
  output logic [3:0] key_code,
  output logic [2:0] key_sign,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DWELL_LAST = 8'(COL_DWELL - 1);

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] dwell_cnt, dwell_n;
  logic [7:0] deb_cnt, deb_n;
  logic [3:0] cand_val, cand_val_n;
  logic [2:0] cand_sign, cand_sign_n;
  logic [3:0] col_n;
  logic [3:0] code_n;
  logic [2:0] sign_n;
  logic       valid_n;
  logic       held_n;
  logic       match;

  assign match = key_pressed &&
                 (key_value == cand_val) &&
                 (is_sign_key == cand_sign);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      state         <= SCAN;
      dwell_cnt     <= '0;
      deb_cnt       <= '0;
      cand_val      <= '0;
      cand_sign     <= '0;
      col_shift_reg <= 4'b1000;
      key_code      <= '0;
      key_sign      <= '0;
      key_valid     <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      state         <= state_n;
      dwell_cnt     <= dwell_n;
      deb_cnt       <= deb_n;
      cand_val      <= cand_val_n;
      cand_sign     <= cand_sign_n;
      col_shift_reg <= col_n;
      key_code      <= code_n;
      key_sign      <= sign_n;
      key_valid     <= valid_n;
      key_held      <= held_n;
    end
  end

  always_comb begin
    state_n     = state;
    dwell_n     = dwell_cnt;
    deb_n       = deb_cnt;
    cand_val_n  = cand_val;
    cand_sign_n = cand_sign;
    col_n       = col_shift_reg;
    code_n      = key_code;
    sign_n      = key_sign;
    valid_n     = 1'b0;
    held_n      = key_held;
    unique case (state)
      SCAN: begin
        // A press freezes the strobe even if the dwell just expired
        if (key_pressed) begin
          cand_val_n  = key_value;
          cand_sign_n = is_sign_key;
          deb_n       = 8'd1;
          state_n     = DEBOUNCE;
        end else if (dwell_cnt == DWELL_LAST) begin
          col_n   = {col_shift_reg[0], col_shift_reg[3:1]};
          dwell_n = '0;
        end else begin
          dwell_n = dwell_cnt + 8'd1;
        end
      end
      DEBOUNCE: begin
        if (match && deb_cnt == DEB_LAST) begin
          code_n  = cand_val;
          sign_n  = cand_sign;
          valid_n = 1'b1;
          held_n  = 1'b1;
          deb_n   = '0;
          state_n = WAIT_RELEASE;
        end else if (match) begin
          deb_n = deb_cnt + 8'd1;
        end else begin
          deb_n   = '0;
          dwell_n = '0;
          state_n = SCAN;
        end
      end
      WAIT_RELEASE: begin
        if (key_pressed) begin
          deb_n = '0;
        end else if (deb_cnt == DEB_LAST) begin
          held_n  = 1'b0;
          col_n   = {col_shift_reg[0], col_shift_reg[3:1]};
          dwell_n = '0;
          deb_n   = '0;
          state_n = SCAN;
        end else begin
          deb_n = deb_cnt + 8'd1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with default parameters
// (DEBOUNCE_CYCLES=4, COL_DWELL=1).
module tb_keypad_scan_ctrl;

  logic       slow_clk = 1'b0;
  logic       rst;
  logic       key_pressed;
  logic [3:0] key_value;
  logic [2:0] is_sign_key;
  logic [3:0] col_shift_reg;
  logic [3:0] key_code;
  logic [2:0] key_sign;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int failures = 0;
  int vcnt;
  logic prev_v;
  logic [3:0] exp_col;

  keypad_scan_ctrl dut (
    .slow_clk      (slow_clk),
    .rst           (rst),
    .key_pressed   (key_pressed),
    .key_value     (key_value),
    .is_sign_key   (is_sign_key),
    .col_shift_reg (col_shift_reg),
    .key_code      (key_code),
    .key_sign      (key_sign),
    .key_valid     (key_valid),
    .key_held      (key_held)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic drive(input logic kp, input logic [3:0] v,
                       input logic [2:0] s);
    key_pressed = kp;
    key_value   = v;
    is_sign_key = s;
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (key_valid) vcnt++;
      if (key_valid && prev_v) chk("valid_back2back", 1, 0);
      prev_v = key_valid;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_col"},   col_shift_reg, 4'b1000);
    chk({tag, "_code"},  key_code, 0);
    chk({tag, "_sign"},  key_sign, 0);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_held"},  key_held, 0);
  endtask

  initial begin
    rst = 1'b1;
    prev_v = 1'b0;
    drive(1'b0, 4'd0, 3'd0);
    repeat (3) step();
    rst = 1'b0;
    chk_reset_outs("reset");

    exp_col = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_col = {exp_col[0], exp_col[3:1]};
      chk("idle_col", col_shift_reg, exp_col);
      chk("idle_valid", key_valid, 0);
    end
    repeat (2) step();
    chk("col_0010", col_shift_reg, 4'b0010);

    drive(1'b1, 4'd7, 3'd0);
    step();
    chk("cap_col", col_shift_reg, 4'b0010);
    chk("cap_valid", key_valid, 0);
    step();
    step();
    chk("deb2_valid", key_valid, 0);
    step();
    chk("press_valid", key_valid, 1);
    chk("press_code", key_code, 7);
    chk("press_sign", key_sign, 0);
    chk("press_held", key_held, 1);
    chk("press_col", col_shift_reg, 4'b0010);
    step();
    chk("press_valid_off", key_valid, 0);
    drive(1'b0, 4'd0, 3'd0);
    repeat (3) step();
    chk("rel3_held", key_held, 1);
    step();
    chk("rel4_held", key_held, 0);
    chk("rel4_col", col_shift_reg, 4'b0001);

    drive(1'b1, 4'd5, 3'd0);
    repeat (2) step();
    drive(1'b0, 4'd0, 3'd0);
    step();
    chk("bounce_valid", key_valid, 0);
    chk("bounce_code", key_code, 7);
    chk("bounce_col", col_shift_reg, 4'b0001);
    step();
    chk("bounce_rotate", col_shift_reg, 4'b1000);
    drive(1'b1, 4'd5, 3'd0);
    vcnt = 0;
    run_count(6);
    chk("stable5_count", vcnt, 1);
    chk("stable5_code", key_code, 5);
    chk("stable5_held", key_held, 1);
    drive(1'b0, 4'd0, 3'd0);
    repeat (4) step();
    chk("stable5_rel", key_held, 0);
    chk("stable5_col", col_shift_reg, 4'b0100);

    drive(1'b1, 4'd0, 3'b010);
    vcnt = 0;
    run_count(50);
    chk("hash_count", vcnt, 1);
    chk("hash_sign", key_sign, 3'b010);
    chk("hash_code", key_code, 0);
    chk("hash_held", key_held, 1);
    drive(1'b0, 4'd0, 3'd0);
    repeat (2) step();
    drive(1'b1, 4'd0, 3'b010);
    step();
    drive(1'b0, 4'd0, 3'd0);
    repeat (3) step();
    chk("glitch_held", key_held, 1);
    chk("glitch_col", col_shift_reg, 4'b0100);
    step();
    chk("hash_rel", key_held, 0);
    chk("hash_col", col_shift_reg, 4'b0010);

    drive(1'b1, 4'hF, 3'b111);
    repeat (3) step();
    chk("d_pre_valid", key_valid, 0);
    step();
    chk("d_valid", key_valid, 1);
    chk("d_code", key_code, 15);
    chk("d_sign", key_sign, 7);
    drive(1'b0, 4'd0, 3'd0);
    repeat (4) step();
    chk("d_rel", key_held, 0);

    drive(1'b1, 4'd3, 3'd0);
    repeat (2) step();
    #2 rst = 1'b1;
    #1 chk_reset_outs("rst_deb");
    #1 rst = 1'b0;
    drive(1'b0, 4'd0, 3'd0);
    vcnt = 0;
    run_count(6);
    chk("rst_deb_novalid", vcnt, 0);

    drive(1'b1, 4'd9, 3'd1);
    repeat (4) step();
    chk("hold9_valid", key_valid, 1);
    step();
    chk("hold9_held", key_held, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outs("rst_hold");
    #1 rst = 1'b0;
    drive(1'b0, 4'd0, 3'd0);
    vcnt = 0;
    run_count(6);
    chk("rst_hold_novalid", vcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
